// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a mem_busy watchdog.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        ID_uses_rt,
  input  logic        ID_Jump,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic        EX_Branch_taken,
  input  logic        mem_busy,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_Flush,
  output logic        ID_Hazard_lwstall,
  output logic        ID_Hazard_Branch,
  output logic        Pipe_Freeze,
  output logic        busy_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, ERR = 2'd2} state_t;

  localparam logic [15:0] TIMEOUT = 16'(BUSY_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] busy_cnt, busy_cnt_nxt;
  logic        lu;
  logic        pcw, ifw, flsh, lws, hbr, frz, bto;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign lu = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
              ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
               (ID_uses_rt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    pcw          = 1'b1;
    ifw          = 1'b1;
    flsh         = 1'b0;
    lws          = 1'b0;
    hbr          = 1'b0;
    frz          = 1'b0;
    bto          = (state == ERR);
    if ((state != ERR) && mem_busy) begin
      frz = 1'b1;
      pcw = 1'b0;
      ifw = 1'b0;
      if (state == RUN) begin
        state_nxt    = HOLD;
        busy_cnt_nxt = 16'd1;
      end else if (busy_cnt == TIMEOUT) begin
        state_nxt = ERR;
      end else begin
        busy_cnt_nxt = busy_cnt + 16'd1;
      end
    end else begin
      // Leaving HOLD still resolves the instructions sitting in ID/EX this cycle.
      if (state == HOLD) begin
        state_nxt    = RUN;
        busy_cnt_nxt = 16'd0;
      end
      if (EX_Branch_taken) begin
        flsh = 1'b1;
        hbr  = 1'b1;
      end else if (lu) begin
        pcw = 1'b0;
        ifw = 1'b0;
        lws = 1'b1;
      end else if (ID_Jump) begin
        flsh = 1'b1;
      end
    end
  end

  // Reset forces every control output low without waiting for a clock edge.
  assign PC_Write          = rst & pcw;
  assign IF_ID_Write       = rst & ifw;
  assign IF_Flush          = rst & flsh;
  assign ID_Hazard_lwstall = rst & lws;
  assign ID_Hazard_Branch  = rst & hbr;
  assign Pipe_Freeze       = rst & frz;
  assign busy_timeout      = rst & bto;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      busy_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (lws)  stall_cnt <= sat_inc(stall_cnt);
      if (flsh) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus busy/timeout/reset sequences.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        rst;
  logic [4:0]  rs, rt, ert;
  logic        urt, jmp, mrd, br, busy;
  logic        pcw, ifw, flsh, lws, hbr, frz, bto;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // exp bits: {PC_Write, IF_ID_Write, IF_Flush, lwstall, Branch, Freeze, timeout}
  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       urt, jmp, mrd;
    logic [4:0] ert;
    logic       br, busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];

  pipeline_hazard_ctrl #(.BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .ID_uses_rt(urt), .ID_Jump(jmp),
    .ID_EX_MemRead(mrd), .ID_EX_RegisterRt(ert), .EX_Branch_taken(br), .mem_busy(busy),
    .PC_Write(pcw), .IF_ID_Write(ifw), .IF_Flush(flsh), .ID_Hazard_lwstall(lws),
    .ID_Hazard_Branch(hbr), .Pipe_Freeze(frz), .busy_timeout(bto),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [4:0] a, logic [4:0] b, logic u, logic j,
                              logic m, logic [4:0] e, logic r, logic y, logic [6:0] x);
    vec_t v;
    v.name = n; v.rs = a; v.rt = b; v.urt = u; v.jmp = j;
    v.mrd = m; v.ert = e; v.br = r; v.busy = y; v.exp = x;
    return v;
  endfunction

  function automatic void check(string n, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endfunction

  function automatic logic [6:0] outs();
    return {pcw, ifw, flsh, lws, hbr, frz, bto};
  endfunction

  function automatic void check_cnts(string n);
    check({n, ".stall_cnt"}, stall_cnt, PERF ? 16'(exp_stall) : 16'h0);
    check({n, ".flush_cnt"}, flush_cnt, PERF ? 16'(exp_flush) : 16'h0);
  endfunction

  // Called just after a falling edge; samples mid-cycle on the rising edge.
  task automatic run_vec(input vec_t v);
    vec_t got;
    rs = v.rs; rt = v.rt; urt = v.urt; jmp = v.jmp;
    mrd = v.mrd; ert = v.ert; br = v.br; busy = v.busy;
    sb.push_back(v);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check(got.name, {9'd0, outs()}, {9'd0, got.exp});
    check_cnts(got.name);
    if (got.exp[3]) exp_stall++;
    if (got.exp[4]) exp_flush++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("normal",     5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 7'b1100000);
    vecs[1]  = mk("lu_rs",      5'd2, 5'd3, 1, 0, 1, 5'd2, 0, 0, 7'b0001000);
    vecs[2]  = mk("after_lu",   5'd2, 5'd3, 1, 0, 0, 5'd0, 0, 0, 7'b1100000);
    vecs[3]  = mk("lu_r0",      5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 7'b1100000);
    vecs[4]  = mk("lu_rt",      5'd1, 5'd5, 1, 0, 1, 5'd5, 0, 0, 7'b0001000);
    vecs[5]  = mk("rt_unused",  5'd1, 5'd5, 0, 0, 1, 5'd5, 0, 0, 7'b1100000);
    vecs[6]  = mk("br_vs_lu",   5'd2, 5'd3, 1, 0, 1, 5'd2, 1, 0, 7'b1110100);
    vecs[7]  = mk("jump",       5'd7, 5'd8, 0, 1, 0, 5'd0, 0, 0, 7'b1110000);
    vecs[8]  = mk("jump_lu",    5'd2, 5'd8, 0, 1, 1, 5'd2, 0, 0, 7'b0001000);
    vecs[9]  = mk("jump_after", 5'd2, 5'd8, 0, 1, 0, 5'd0, 0, 0, 7'b1110000);
    vecs[10] = mk("br_plain",   5'd4, 5'd4, 1, 0, 0, 5'd0, 1, 0, 7'b1110100);

    rst = 1'b0; rs = 0; rt = 0; urt = 0; jmp = 0; mrd = 0; ert = 0; br = 0; busy = 1'b1;
    #2;
    check("reset_outs", {9'd0, outs()}, 16'd0);
    check_cnts("reset");
    @(negedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    for (int i = 0; i < 3; i++) run_vec(mk("busy3", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 1, 7'b0000010));
    run_vec(mk("busy3_release", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 7'b1100000));

    for (int i = 0; i < 2; i++) run_vec(mk("busy_br", 5'd1, 5'd2, 1, 0, 0, 5'd0, 1, 1, 7'b0000010));
    run_vec(mk("busy_exit_br", 5'd1, 5'd2, 1, 0, 0, 5'd0, 1, 0, 7'b1110100));

    for (int i = 0; i < 5; i++) run_vec(mk("timeout_freeze", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 1, 7'b0000010));
    for (int i = 0; i < 5; i++) run_vec(mk("err_busy", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 1, 7'b1100001));
    run_vec(mk("err_lu", 5'd3, 5'd2, 1, 0, 1, 5'd3, 0, 1, 7'b0001001));
    run_vec(mk("err_idle", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 7'b1100001));

    // Reset clears ERR; then enter HOLD and abort it with reset.
    rst = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0;
    check("rst_from_err", {9'd0, outs()}, 16'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) run_vec(mk("hold_pre_rst", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 1, 7'b0000010));
    rst = 1'b0;
    #1;
    check("rst_mid_hold", {9'd0, outs()}, 16'd0);
    check_cnts("rst_mid_hold");
    @(negedge clk);
    #1;
    rst = 1'b1;
    run_vec(mk("post_rst_run", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 7'b1100000));
    run_vec(mk("post_rst_lu", 5'd6, 5'd2, 1, 0, 1, 5'd6, 0, 0, 7'b0001000));
    run_vec(mk("post_rst_end", 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 7'b1100000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
